// File: rtl/pipeline_stall_ctrl_pkg.sv
// ============================================================================
// pipeline_stall_ctrl_pkg : shared stall-bus encodings and FSM state codes
// Revision: 1.0
// ============================================================================
`default_nettype none

package pipeline_stall_ctrl_pkg;

    localparam int STALL_W  = 6;
    localparam int STALL_PC = 0;
    localparam int STALL_IF = 1;
    localparam int STALL_ID = 2;
    localparam int STALL_EX = 3;

    // Each pattern freezes everything upstream of the stage that takes the bubble
    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_IFWAIT  = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_MC      = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM     = 6'b011111;

    typedef enum logic [0:0] {
        S_RUN = 1'b0,
        S_MC  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_if.sv
// ============================================================================
// pipeline_stall_ctrl_if : pipeline request / stall-control bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pipeline_stall_ctrl_if
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int PERF_W = 32
);
    logic               id_read_en_1;
    logic [4:0]         id_reg_addr_1;
    logic               id_read_en_2;
    logic [4:0]         id_reg_addr_2;
    logic               ex_mem_read;
    logic [4:0]         ex_write_addr;
    logic               ex_mc_start;
    logic               if_stall_req;
    logic               mem_stall_req;
    logic               flush_req;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               mc_busy;
    logic               mc_done;
    logic [PERF_W-1:0]  stall_cycles;

    modport master (
        output id_read_en_1, id_reg_addr_1, id_read_en_2, id_reg_addr_2,
        output ex_mem_read, ex_write_addr, ex_mc_start,
        output if_stall_req, mem_stall_req, flush_req,
        input  stall, flush, mc_busy, mc_done, stall_cycles
    );

    modport slave (
        input  id_read_en_1, id_reg_addr_1, id_read_en_2, id_reg_addr_2,
        input  ex_mem_read, ex_write_addr, ex_mc_start,
        input  if_stall_req, mem_stall_req, flush_req,
        output stall, flush, mc_busy, mc_done, stall_cycles
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// ============================================================================
// pipeline_stall_ctrl_hazard_detect : load-use compare of ID reads vs EX load
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl_hazard_detect (
    input  wire logic       read_en_1,
    input  wire logic [4:0] reg_addr_1,
    input  wire logic       read_en_2,
    input  wire logic [4:0] reg_addr_2,
    input  wire logic       mem_read,
    input  wire logic [4:0] write_addr,
    output logic            load_use
);
    logic hit_1;
    logic hit_2;

    assign hit_1    = read_en_1 && (reg_addr_1 == write_addr);
    assign hit_2    = read_en_2 && (reg_addr_2 == write_addr);
    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign load_use = mem_read && (write_addr != 5'd0) && (hit_1 || hit_2);

endmodule

`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
// ============================================================================
// pipeline_stall_ctrl : stall/flush sequencer for the 5-stage pipeline.
// Optional stall performance counter enabled by `STALL_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int MC_CYCLES = 32,
    parameter int CNT_W     = 6,
    parameter int PERF_W    = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pipeline_stall_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_CYCLES - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               load_use;
    logic [STALL_W-1:0] stall_c;
    logic               flush_c;
    logic               busy_c;
    logic               done_c;

    pipeline_stall_ctrl_hazard_detect u_hazard (
        .read_en_1  (bus.id_read_en_1),
        .reg_addr_1 (bus.id_reg_addr_1),
        .read_en_2  (bus.id_read_en_2),
        .reg_addr_2 (bus.id_reg_addr_2),
        .mem_read   (bus.ex_mem_read),
        .write_addr (bus.ex_write_addr),
        .load_use   (load_use)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_c   = STALL_NONE;
        flush_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        if (bus.flush_req) begin
            flush_c   = 1'b1;
            state_nxt = S_RUN;
            cnt_nxt   = '0;
        end else if (bus.mem_stall_req) begin
            // Countdown frozen; an op already in flight still reports busy
            stall_c = STALL_MEM;
            busy_c  = (state == S_MC) && (cnt != '0);
        end else if (state == S_MC) begin
            if (cnt != '0) begin
                stall_c = STALL_MC;
                busy_c  = 1'b1;
                cnt_nxt = cnt - CNT_W'(1);
            end else begin
                done_c    = 1'b1;
                state_nxt = S_RUN;
            end
        end else if (bus.ex_mc_start) begin
            stall_c   = STALL_MC;
            busy_c    = 1'b1;
            cnt_nxt   = MC_LOAD;
            state_nxt = S_MC;
        end else if (load_use) begin
            stall_c = STALL_LOADUSE;
        end else if (bus.if_stall_req) begin
            stall_c = STALL_IFWAIT;
        end
    end

    assign bus.stall   = rst ? stall_c : STALL_NONE;
    assign bus.flush   = rst & flush_c;
    assign bus.mc_busy = rst & busy_c;
    assign bus.mc_done = rst & done_c;

`ifdef STALL_PERF_CNT_EN
    logic [PERF_W-1:0] perf_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cnt <= '0;
        end else if (stall_c[STALL_ID] && (perf_cnt != {PERF_W{1'b1}})) begin
            perf_cnt <= perf_cnt + PERF_W'(1);
        end
    end

    assign bus.stall_cycles = perf_cnt;
`else
    assign bus.stall_cycles = {PERF_W{1'b0}};
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
// ============================================================================
// tb_pipeline_stall_ctrl : vector table + scoreboard bench for pipeline_stall_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    localparam int MC = 4;

    localparam logic [3:0] R_MC  = 4'b1000;
    localparam logic [3:0] R_IF  = 4'b0100;
    localparam logic [3:0] R_MEM = 4'b0010;
    localparam logic [3:0] R_FL  = 4'b0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.PERF_W(32)) bus ();

    pipeline_stall_ctrl #(
        .MC_CYCLES (MC),
        .CNT_W     (3),
        .PERF_W    (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst_n;
        logic       en1;
        logic [4:0] a1;
        logic       en2;
        logic [4:0] a2;
        logic       mrd;
        logic [4:0] wa;
        logic [3:0] req;
        logic [5:0] e_stall;
        logic [2:0] e_fbd;
        logic       chk_busy;
    } vec_t;

    typedef struct {
        logic [5:0] stall;
        logic [2:0] fbd;
        logic       chk_busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic e1, input logic [4:0] x1,
                                input logic e2, input logic [4:0] x2, input logic mrd,
                                input logic [4:0] wa, input logic [3:0] req,
                                input logic [5:0] es, input logic [2:0] efbd,
                                input logic cb);
        vec_t v;
        v.rst_n = r;   v.en1 = e1; v.a1 = x1; v.en2 = e2; v.a2 = x2;
        v.mrd = mrd;   v.wa = wa;  v.req = req;
        v.e_stall = es; v.e_fbd = efbd; v.chk_busy = cb;
        return v;
    endfunction

    function automatic vec_t ctl(input logic [3:0] req, input logic [5:0] es,
                                 input logic [2:0] efbd, input logic cb);
        return mk(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, req, es, efbd, cb);
    endfunction

    task automatic step(input vec_t v, input string tag);
        exp_t       e;
        logic [2:0] got_fbd;
        @(negedge clk);
        rst               = v.rst_n;
        bus.id_read_en_1  = v.en1;
        bus.id_reg_addr_1 = v.a1;
        bus.id_read_en_2  = v.en2;
        bus.id_reg_addr_2 = v.a2;
        bus.ex_mem_read   = v.mrd;
        bus.ex_write_addr = v.wa;
        bus.ex_mc_start   = v.req[3];
        bus.if_stall_req  = v.req[2];
        bus.mem_stall_req = v.req[1];
        bus.flush_req     = v.req[0];
        e.stall = v.e_stall; e.fbd = v.e_fbd; e.chk_busy = v.chk_busy;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        got_fbd = {bus.flush, bus.mc_busy, bus.mc_done};
        if (!e.chk_busy) begin
            got_fbd[1] = 1'b0;
            e.fbd[1]   = 1'b0;
        end
        n_cmp++;
        if (bus.stall !== e.stall || got_fbd !== e.fbd) begin
            n_err++;
            $display("FAIL %s: got stall=%b flush/busy/done=%b, expected stall=%b flush/busy/done=%b",
                     tag, bus.stall, got_fbd, e.stall, e.fbd);
        end
    endtask

    task automatic check_perf(input logic [31:0] exp_val, input string tag);
        n_cmp++;
        if (bus.stall_cycles !== exp_val) begin
            n_err++;
            $display("FAIL %s: got stall_cycles=%0d, expected %0d", tag, bus.stall_cycles, exp_val);
        end
    endtask

    vec_t       tbl[13];
    logic [31:0] perf_exp;

    initial begin
        bus.id_read_en_1 = 1'b0; bus.id_reg_addr_1 = 5'd0;
        bus.id_read_en_2 = 1'b0; bus.id_reg_addr_2 = 5'd0;
        bus.ex_mem_read  = 1'b0; bus.ex_write_addr = 5'd0;
        bus.ex_mc_start  = 1'b0; bus.if_stall_req  = 1'b0;
        bus.mem_stall_req = 1'b0; bus.flush_req    = 1'b0;

        tbl[0]  = ctl(4'b0, 6'b000000, 3'b000, 1'b1);
        tbl[1]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd8,  4'b0, 6'b000111, 3'b000, 1'b1);
        tbl[2]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  4'b0, 6'b000000, 3'b000, 1'b1);
        tbl[3]  = mk(1'b1, 1'b1, 5'd17, 1'b0, 5'd0,  1'b1, 5'd17, 4'b0, 6'b000111, 3'b000, 1'b1);
        tbl[4]  = mk(1'b1, 1'b0, 5'd17, 1'b0, 5'd17, 1'b1, 5'd17, 4'b0, 6'b000000, 3'b000, 1'b1);
        tbl[5]  = mk(1'b1, 1'b1, 5'd17, 1'b1, 5'd17, 1'b0, 5'd17, 4'b0, 6'b000000, 3'b000, 1'b1);
        tbl[6]  = mk(1'b1, 1'b1, 5'd3,  1'b1, 5'd4,  1'b1, 5'd5,  4'b0, 6'b000000, 3'b000, 1'b1);
        tbl[7]  = ctl(R_IF, 6'b000011, 3'b000, 1'b1);
        tbl[8]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd8,  R_IF,  6'b000111, 3'b000, 1'b1);
        tbl[9]  = mk(1'b1, 1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd8,  R_MEM, 6'b011111, 3'b000, 1'b1);
        tbl[10] = mk(1'b1, 1'b0, 5'd0,  1'b1, 5'd8,  1'b1, 5'd8,  R_FL | R_MEM | R_IF,
                     6'b000000, 3'b100, 1'b1);
        tbl[11] = ctl(R_MEM | R_IF, 6'b011111, 3'b000, 1'b1);
        tbl[12] = ctl(4'b0, 6'b000000, 3'b000, 1'b1);

        // Reset holds outputs low even with a multi-cycle request present
        step(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, R_MC, 6'b0, 3'b000, 1'b1), "reset_c0");
        step(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, R_MC, 6'b0, 3'b000, 1'b1), "reset_c1");
        check_perf(32'd0, "perf_after_reset");
        step(ctl(4'b0, 6'b0, 3'b000, 1'b1), "run_after_reset");

        for (int i = 0; i < 13; i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Multi-cycle op: MC stalled cycles then a done pulse
        step(ctl(R_MC, 6'b001111, 3'b010, 1'b1), "mc_start");
        step(ctl(R_MC, 6'b001111, 3'b010, 1'b1), "mc_c1_restart_ignored");
        step(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd8, 4'b0, 6'b001111, 3'b010, 1'b1),
             "mc_c2_loaduse_ignored");
        step(ctl(4'b0, 6'b001111, 3'b010, 1'b1), "mc_c3");
        step(ctl(4'b0, 6'b000000, 3'b001, 1'b1), "mc_done");
        step(ctl(4'b0, 6'b000000, 3'b000, 1'b1), "mc_after");

        // Memory wait mid-op pauses the countdown
        step(ctl(R_MC, 6'b001111, 3'b010, 1'b1), "mcm_start");
        step(ctl(4'b0, 6'b001111, 3'b010, 1'b1), "mcm_c1");
        for (int i = 0; i < 3; i++) begin
            step(ctl(R_MEM, 6'b011111, 3'b000, 1'b0), $sformatf("mcm_mem%0d", i));
        end
        step(ctl(4'b0, 6'b001111, 3'b010, 1'b1), "mcm_c2");
        step(ctl(4'b0, 6'b001111, 3'b010, 1'b1), "mcm_c3");
        step(ctl(4'b0, 6'b000000, 3'b001, 1'b1), "mcm_done");
        step(ctl(4'b0, 6'b000000, 3'b000, 1'b1), "mcm_after");

        // Flush aborts the op: no done pulse afterwards
        step(ctl(R_MC, 6'b001111, 3'b010, 1'b1), "fl_start");
        step(ctl(R_FL, 6'b000000, 3'b100, 1'b1), "fl_flush");
        for (int i = 0; i < 4; i++) begin
            step(ctl(4'b0, 6'b000000, 3'b000, 1'b1), $sformatf("fl_after%0d", i));
        end

        // Stall counter: one MC op plus one load-use
        step(mk(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 4'b0, 6'b0, 3'b000, 1'b1), "perf_rst");
        step(ctl(R_MC, 6'b001111, 3'b010, 1'b1), "perf_mc_start");
        check_perf(32'd0, "perf_cleared");
        for (int i = 1; i < MC; i++) begin
            step(ctl(4'b0, 6'b001111, 3'b010, 1'b1), $sformatf("perf_mc%0d", i));
        end
        step(ctl(4'b0, 6'b000000, 3'b001, 1'b1), "perf_mc_done");
        step(mk(1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, 5'd8, 4'b0, 6'b000111, 3'b000, 1'b1),
             "perf_loaduse");
        step(ctl(4'b0, 6'b000000, 3'b000, 1'b1), "perf_idle");
`ifdef STALL_PERF_CNT_EN
        perf_exp = 32'd5;
`else
        perf_exp = 32'd0;
`endif
        check_perf(perf_exp, "perf_total");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
